nn_update_epoch_scheduler: RTL

- Sequences a bank of NP smooth-gradient polar parameter updaters through a training run: one INIT pulse, then repeated epochs, each a settle phase followed by an update window.
- Drives the shared INIT and EN lines of the bank and collects each updater's DIRECTION_CHANGE flag.
- At the end of every epoch it counts oscillating parameters and ends the run when the bank has converged or the epoch budget is spent.

---
 rtl/nn_update_epoch_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nn_update_epoch_scheduler.sv
// nn_update_epoch_scheduler: sequences an updater bank through INIT, then settle/update epochs until
// the bank converges (enough consecutive calm epochs) or the epoch budget runs out.
module nn_update_epoch_scheduler #(
    parameter int NP          = 16,
    parameter int N_WIN       = 12,
    parameter int N_EPOCH     = 10,
    parameter int N_PAT       = 4,
    parameter int INIT_CYCLES = 2,
    localparam int NO         = $clog2(NP + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [N_WIN-1:0]   window_len_i,
    input  logic [N_WIN-1:0]   settle_len_i,
    input  logic [N_EPOCH-1:0] max_epoch_i,
    input  logic [NO-1:0]      conv_thresh_i,
    input  logic [N_PAT-1:0]   conv_patience_i,
    input  logic [NP-1:0]      dir_change_i,
    output logic               init_o,
    output logic               en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               converged_o,
    output logic [N_EPOCH-1:0] epoch_count_o,
    output logic [NO-1:0]      osc_count_o
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SETTLE, S_UPDATE, S_EVAL, S_DONE} state_t;

    localparam logic [N_WIN-1:0] INIT_LAST = N_WIN'(INIT_CYCLES - 1);

    state_t             state_q, state_d, first_ph;
    logic [N_WIN-1:0]   cnt_q, cnt_d, win_q, settle_q;
    logic [N_EPOCH-1:0] max_q, epoch_q, epoch_d, epoch_next;
    logic [NO-1:0]      thresh_q, osc_q, osc_d, osc_now;
    logic [N_PAT-1:0]   pat_q, calm_q, calm_d, calm_next;
    logic [NP-1:0]      sticky_q, sticky_d, flags;
    logic               conv_q, conv_d, load;
    logic               init_q, en_q, busy_q, done_q;

    assign init_o        = init_q;
    assign en_o          = en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign converged_o   = conv_q;
    assign epoch_count_o = epoch_q;
    assign osc_count_o   = osc_q;

    assign first_ph   = settle_q == '0 ? S_UPDATE : S_SETTLE;
    // Flags raised in the EVAL cycle itself still belong to the epoch just ending.
    assign flags      = sticky_q | dir_change_i;
    assign epoch_next = epoch_q + N_EPOCH'(1);
    assign calm_next  = osc_now > thresh_q ? '0 : (calm_q == '1 ? calm_q : calm_q + N_PAT'(1));

    always_comb begin
        osc_now = '0;
        for (int i = 0; i < NP; i++) osc_now = osc_now + NO'(flags[i]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        calm_d   = calm_q;
        epoch_d  = epoch_q;
        osc_d    = osc_q;
        conv_d   = conv_q;
        load     = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_i) begin
                    state_d  = S_INIT;
                    cnt_d    = '0;
                    sticky_d = '0;
                    calm_d   = '0;
                    epoch_d  = '0;
                    osc_d    = '0;
                    conv_d   = 1'b0;
                    load     = 1'b1;
                end
                S_INIT: begin
                    state_d = cnt_q == INIT_LAST ? first_ph : S_INIT;
                    cnt_d   = cnt_q == INIT_LAST ? '0 : cnt_q + N_WIN'(1);
                end
                S_SETTLE: begin
                    state_d = cnt_q == settle_q - N_WIN'(1) ? S_UPDATE : S_SETTLE;
                    cnt_d   = cnt_q == settle_q - N_WIN'(1) ? '0 : cnt_q + N_WIN'(1);
                end
                S_UPDATE: begin
                    sticky_d = flags;
                    state_d  = cnt_q == win_q - N_WIN'(1) ? S_EVAL : S_UPDATE;
                    cnt_d    = cnt_q == win_q - N_WIN'(1) ? '0 : cnt_q + N_WIN'(1);
                end
                S_EVAL: begin
                    osc_d    = osc_now;
                    epoch_d  = epoch_next;
                    calm_d   = calm_next;
                    sticky_d = '0;
                    conv_d   = calm_next == pat_q;
                    state_d  = (calm_next == pat_q || epoch_next == max_q) ? S_DONE : first_ph;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            settle_q <= '0;
            max_q    <= '0;
            thresh_q <= '0;
            pat_q    <= '0;
            sticky_q <= '0;
            calm_q   <= '0;
            epoch_q  <= '0;
            osc_q    <= '0;
            conv_q   <= 1'b0;
            init_q   <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            calm_q   <= calm_d;
            epoch_q  <= epoch_d;
            osc_q    <= osc_d;
            conv_q   <= conv_d;
            init_q   <= state_d == S_INIT;
            en_q     <= state_d == S_UPDATE;
            busy_q   <= !(state_d inside {S_IDLE, S_DONE});
            done_q   <= state_d == S_DONE;
            if (load) begin
                // Zero lengths/budgets are stored as 1 so the compares below need no special case.
                win_q    <= window_len_i == '0 ? N_WIN'(1) : window_len_i;
                settle_q <= settle_len_i;
                max_q    <= max_epoch_i == '0 ? N_EPOCH'(1) : max_epoch_i;
                thresh_q <= conv_thresh_i;
                pat_q    <= conv_patience_i == '0 ? N_PAT'(1) : conv_patience_i;
            end
        end
    end
endmodule
